reg_bank_sb: RTL and testbench

Parametrised successor to the 16x32 register bank. It keeps the 2-read/1-write register file with registered reads and a debug tap. New behaviour: a per-register pending-write scoreboard for hazard detection and a sequential bulk-clear engine. It sits between decode (read and scoreboard ports) and writeback (write port) in the core datapath.

---
 rtl/reg_bank_sb.sv | 97 +++++++++
 tb/tb_reg_bank_sb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: 2R1W register bank with pending-write scoreboard and sequential bulk clear; define REG_BANK_SB_BYPASS_EN for write-through reads
module reg_bank_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int DEBUG_IDX = 13,
  parameter int ZERO_REG  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  input  logic              clr_req,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [DATA_W-1:0] debug,
  output logic              clr_busy
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] DBG = ADDR_W'(DEBUG_IDX);
  localparam bit ZR = (ZERO_REG != 0);
`ifdef REG_BANK_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [ADDR_W-1:0] cnt;
  logic we, bs;
  logic [DATA_W-1:0] rs1_nx, rs2_nx, rd_nx;
  always_comb begin
    we = reg_write && state == IDLE && !(ZR && rd_addr == '0);
    bs = busy_set && state == IDLE && !(ZR && busy_addr == '0);
    state_nx = state == IDLE ? (clr_req ? CLEAR : IDLE) : (cnt == LAST ? IDLE : CLEAR);
    rs1_nx = (BYP && we && rs1_addr == rd_addr) ? write_data :
             (ZR && rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_nx = (BYP && we && rs2_addr == rd_addr) ? write_data :
             (ZR && rs2_addr == '0) ? '0 : regs[rs2_addr];
    rd_nx = (ZR && rd_addr == '0) ? '0 : regs[rd_addr];
  end
  assign clr_busy = (state == CLEAR);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == CLEAR ? cnt + 1'b1 : '0;
    end
  end
  // a new producer issued in the same cycle as a writeback keeps the register busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (state == CLEAR && cnt == ADDR_W'(i)) begin
          regs[i] <= '0;
          busy[i] <= 1'b0;
        end else begin
          if (we && rd_addr == ADDR_W'(i)) regs[i] <= write_data;
          if (bs && busy_addr == ADDR_W'(i)) busy[i] <= 1'b1;
          else if (we && rd_addr == ADDR_W'(i)) busy[i] <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_data <= '0;
      rs2_data <= '0;
      rd_data <= '0;
      rs1_busy <= 1'b0;
      rs2_busy <= 1'b0;
      debug <= '0;
    end else begin
      rs1_data <= rs1_nx;
      rs2_data <= rs2_nx;
      rd_data <= rd_nx;
      rs1_busy <= busy[rs1_addr];
      rs2_busy <= busy[rs2_addr];
      debug <= regs[DBG];
    end
  end
endmodule

// File: tb/tb_reg_bank_sb.sv
// tb_reg_bank_sb: directed checks of reg_bank_sb reads, writes, scoreboard and bulk clear
module tb_reg_bank_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] rd_addr = '0, rs1_addr = '0, rs2_addr = '0, busy_addr = '0;
  logic [31:0] write_data = '0;
  logic reg_write = 1'b0, busy_set = 1'b0, clr_req = 1'b0;
  logic [31:0] rs1_data, rs2_data, rd_data, debug;
  logic rs1_busy, rs2_busy, clr_busy;
  int checks = 0;
  int errors = 0;
  int cnt;

  reg_bank_sb dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .write_data(write_data), .reg_write(reg_write), .busy_set(busy_set), .busy_addr(busy_addr),
    .clr_req(clr_req), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_data(rd_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .debug(debug), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    rd_addr = a;
    write_data = d;
    reg_write = 1'b1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_rs1", rs1_data, 0);
    chk("rst_dbg", debug, 0);
    chk("rst_clr", {31'd0, clr_busy}, 0);
    rst_n = 1'b1;
    // reg3 write, read visible the next edge
    wr(3, 32'hDEADBEEF);
    rs1_addr = 3;
    tick();
`ifdef REG_BANK_SB_BYPASS_EN
    chk("wr3_same", rs1_data, 32'hDEADBEEF);
`else
    chk("wr3_same", rs1_data, 0);
`endif
    reg_write = 1'b0;
    tick();
    chk("wr3_rs1", rs1_data, 32'hDEADBEEF);
    chk("wr3_rd", rd_data, 32'hDEADBEEF);
    // register 0 is hardwired zero
    wr(0, 32'h1234);
    rs2_addr = 0;
    tick();
    reg_write = 1'b0;
    tick();
    chk("zero_reg", rs2_data, 0);
    wr(13, 32'h55);
    tick();
    reg_write = 1'b0;
    chk("dbg_early", debug, 0);
    tick();
    chk("dbg_late", debug, 32'h55);
    // same-cycle write and read of reg7
    wr(7, 32'h1);
    tick();
    wr(7, 32'h2);
    rs1_addr = 7;
    tick();
    reg_write = 1'b0;
`ifdef REG_BANK_SB_BYPASS_EN
    chk("byp_same", rs1_data, 32'h2);
`else
    chk("byp_same", rs1_data, 32'h1);
`endif
    tick();
    chk("byp_next", rs1_data, 32'h2);
    // scoreboard
    busy_set = 1'b1;
    busy_addr = 4;
    rs2_addr = 4;
    tick();
    busy_set = 1'b0;
    chk("sb_pre", {31'd0, rs2_busy}, 0);
    tick();
    chk("sb_set", {31'd0, rs2_busy}, 1);
    wr(4, 32'h9);
    tick();
    reg_write = 1'b0;
    tick();
    chk("sb_wb_clr", {31'd0, rs2_busy}, 0);
    wr(4, 32'hAB);
    busy_set = 1'b1;
    tick();
    reg_write = 1'b0;
    busy_set = 1'b0;
    tick();
    chk("sb_set_wins", {31'd0, rs2_busy}, 1);
    chk("sb_set_data", rs2_data, 32'hAB);
    busy_set = 1'b1;
    busy_addr = 0;
    rs1_addr = 0;
    tick();
    busy_set = 1'b0;
    tick();
    chk("sb_zero", {31'd0, rs1_busy}, 0);
    // fill everything, then bulk clear
    for (int i = 1; i < 16; i++) begin
      wr(4'(i), 32'hFFFFFFFF);
      busy_set = 1'b1;
      busy_addr = 4'(i);
      tick();
    end
    reg_write = 1'b0;
    busy_set = 1'b0;
    rs1_addr = 15;
    rs2_addr = 2;
    tick();
    chk("fill_data", rs1_data, 32'hFFFFFFFF);
    chk("fill_busy", {31'd0, rs2_busy}, 1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_start", {31'd0, clr_busy}, 1);
    cnt = 0;
    while (clr_busy && cnt < 40) begin
      cnt++;
      reg_write = (cnt == 6);
      busy_set = (cnt == 6);
      rd_addr = 2;
      busy_addr = 2;
      write_data = 32'h1234;
      tick();
    end
    reg_write = 1'b0;
    busy_set = 1'b0;
    chk("clr_len", cnt, 16);
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 4'(i);
      rs2_addr = 4'(i);
      tick();
      chk($sformatf("clr_reg%0d", i), rs1_data, 0);
      chk($sformatf("clr_busy%0d", i), {31'd0, rs2_busy}, 0);
    end
    // reset during clear
    wr(5, 32'h77);
    tick();
    reg_write = 1'b0;
    rs1_addr = 5;
    tick();
    chk("pre_rst", rs1_data, 32'h77);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (5) tick();
    chk("mid_clr", {31'd0, clr_busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clr", {31'd0, clr_busy}, 0);
    chk("async_rs1", rs1_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst5", rs1_data, 0);
    tick();
    chk("post_rst_idle", {31'd0, clr_busy}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
